// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like memory responder.
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic        is_write;
    logic [31:0] data;
    logic [3:0]  timer;
  } resp_entry_t;

  function automatic logic [31:0] merge_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_like_mem_slave_if.sv
// SRAM-like request/response bundle between a pipeline stage and its memory.
interface sram_like_mem_slave_if;
  logic        sram_req;
  logic        sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_wdata;
  logic        sram_addr_ok;
  logic        sram_data_ok;
  logic [31:0] sram_rdata;

  modport master (
    output sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
    input  sram_addr_ok, sram_data_ok, sram_rdata
  );

  modport slave (
    input  sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
    output sram_addr_ok, sram_data_ok, sram_rdata
  );
endinterface

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue; every valid entry counts its timer down to zero.
module sram_like_resp_fifo
  import sram_like_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  resp_entry_t               push_entry,
  input  logic                      pop,
  output resp_entry_t               head,
  output logic [$clog2(QDEPTH):0]   count,
  output logic                      full,
  output logic                      head_ready
);

  localparam int unsigned PW = $clog2(QDEPTH);

  resp_entry_t       entries_q [QDEPTH];
  logic [QDEPTH-1:0] valid_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (valid_q[i] && entries_q[i].timer != 4'd0) begin
          entries_q[i].timer <= entries_q[i].timer - 4'd1;
        end
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      // Push never targets a live slot: the requester is refused while full.
      if (push) begin
        entries_q[wr_ptr_q] <= push_entry;
        valid_q[wr_ptr_q]   <= 1'b1;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign head       = entries_q[rd_ptr_q];
  assign head_ready = valid_q[rd_ptr_q] && (head.timer == 4'd0);
  assign count      = count_q;
  assign full       = (count_q == (PW+1)'(QDEPTH));

endmodule

// File: rtl/sram_like_mem_slave.sv
// Word-organised on-chip memory answering SRAM-like requests in order with fixed latency.
// Optional random accept stalls: define SRAM_LIKE_RAND_STALL_EN.
module sram_like_mem_slave
  import sram_like_pkg::*;
#(
  parameter int unsigned MEM_AW  = 12,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 4
) (
  input logic                  clk,
  input logic                  reset,
  sram_like_mem_slave_if.slave bus
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [31:0]       mem [2**MEM_AW];
  logic [MEM_AW-1:0] word_idx;
  logic [31:0]       rd_word;
  logic              addr_ok, accept, full, head_ready;
  logic [CW-1:0]     count;
  resp_entry_t       push_entry, head;
  logic [31:0]       rdata_q;

  assign word_idx = bus.sram_addr[MEM_AW+1:2];
  assign rd_word  = mem[word_idx];

`ifdef SRAM_LIKE_RAND_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign addr_ok = ~full & lfsr_q[0];
`else
  assign addr_ok = ~full;
`endif

  assign accept = bus.sram_req & addr_ok;

  // Writes land at the accept edge, so any later read sees them.
  always_ff @(posedge clk) begin
    if (accept && bus.sram_wr) begin
      mem[word_idx] <= merge_wstrb(rd_word, bus.sram_wdata, bus.sram_wstrb);
    end
  end

  always_comb begin
    push_entry          = '0;
    push_entry.is_write = bus.sram_wr;
    push_entry.data     = bus.sram_wr ? 32'h0 : rd_word;
    push_entry.timer    = 4'(LATENCY - 1);
  end

  sram_like_resp_fifo #(
    .QDEPTH(QDEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_entry(push_entry),
    .pop       (head_ready),
    .head      (head),
    .count     (count),
    .full      (full),
    .head_ready(head_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (head_ready) begin
      rdata_q <= head.data;
    end
  end

  assign bus.sram_addr_ok = addr_ok;
  assign bus.sram_data_ok = head_ready;
  assign bus.sram_rdata   = head_ready ? head.data : rdata_q;

  // Size and sub-word address bits are the requester's business; aliasing is intended.
  logic unused_bits;
  assign unused_bits = ^{bus.sram_size, bus.sram_addr[31:MEM_AW+2], bus.sram_addr[1:0],
                         count, head.is_write};

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Directed bench for sram_like_mem_slave at latencies 1, 2 and 8.
module tb_sram_like_mem_slave;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_like_mem_slave_if bus2 ();
  sram_like_mem_slave_if bus8 ();
  sram_like_mem_slave_if bus1 ();

  sram_like_mem_slave #(.MEM_AW(12), .LATENCY(2), .QDEPTH(4)) u_d2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));
  sram_like_mem_slave #(.MEM_AW(12), .LATENCY(8), .QDEPTH(4)) u_d8 (
    .clk(clk), .reset(reset), .bus(bus8.slave));
  sram_like_mem_slave #(.MEM_AW(12), .LATENCY(1), .QDEPTH(4)) u_d1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vt [18];
  logic [31:0] pre8 [4];
  logic [31:0] pre1 [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic req, input logic wr, input logic [31:0] addr,
                              input logic [3:0] wstrb, input logic [31:0] wdata,
                              input logic aok, input logic dok, input logic [31:0] rdata);
    vec_t v;
    v.req = req; v.wr = wr; v.addr = addr; v.wstrb = wstrb; v.wdata = wdata;
    v.aok = aok; v.dok = dok; v.rdata = rdata;
    return v;
  endfunction

  task automatic idle_all();
    bus2.sram_req = 0; bus2.sram_wr = 0; bus2.sram_size = 2'd2; bus2.sram_addr = 0;
    bus2.sram_wstrb = 0; bus2.sram_wdata = 0;
    bus8.sram_req = 0; bus8.sram_wr = 0; bus8.sram_size = 2'd2; bus8.sram_addr = 0;
    bus8.sram_wstrb = 0; bus8.sram_wdata = 0;
    bus1.sram_req = 0; bus1.sram_wr = 0; bus1.sram_size = 2'd2; bus1.sram_addr = 0;
    bus1.sram_wstrb = 0; bus1.sram_wdata = 0;
  endtask

`ifdef SRAM_LIKE_RAND_STALL_EN
  logic [15:0] lfsr_m;
  logic [31:0] mm [16];
  logic [31:0] expq [$];

  always @(posedge clk) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  task automatic rand_cycle_checks();
    chk("rs_aok", 32'(bus2.sram_addr_ok), 32'(lfsr_m[0]));
    if (bus2.sram_data_ok) begin
      if (expq.size() == 0) begin
        chk("rs_spurious_dok", 32'(bus2.sram_data_ok), 32'h0);
      end else begin
        chk("rs_rdata", bus2.sram_rdata, expq.pop_front());
      end
    end
  endtask
`endif

  initial begin
    idle_all();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_aok", 32'(bus2.sram_addr_ok), 32'h1);
    chk("rst_dok", 32'(bus2.sram_data_ok), 32'h0);
    chk("rst_rdata", bus2.sram_rdata, 32'h0);

`ifdef SRAM_LIKE_RAND_STALL_EN
    for (int n = 0; n < 116; n++) begin
      logic        w;
      int          idx;
      int          waited;
      logic [31:0] d;
      w   = (n < 16) ? 1'b1 : 1'($urandom_range(1));
      idx = (n < 16) ? n : int'($urandom_range(15));
      d   = $urandom;
      bus2.sram_req = 1; bus2.sram_wr = w; bus2.sram_addr = 32'(idx * 4);
      bus2.sram_wstrb = 4'hF; bus2.sram_wdata = d;
      waited = 0;
      while (1) begin
        logic acc;
        rand_cycle_checks();
        acc = bus2.sram_addr_ok;
        if (acc) begin
          if (w) begin
            mm[idx] = d;
            expq.push_back(32'h0);
          end else begin
            expq.push_back(mm[idx]);
          end
        end
        tick();
        if (acc) break;
        waited++;
        if (waited > 64) begin
          chk("rs_accept_timeout", 32'(waited), 32'h0);
          break;
        end
      end
    end
    bus2.sram_req = 0;
    for (int c = 0; c < 10; c++) begin
      rand_cycle_checks();
      tick();
    end
    chk("rs_all_answered", 32'(expq.size()), 32'h0);
`else
    // LATENCY 2: writes, strobes, aliasing, no-op write, held rdata
    vt[0]  = mk(1, 1, 32'h1000, 4'hF, 32'hDEADBEEF, 1, 0, 32'h0);
    vt[1]  = mk(1, 0, 32'h1000, 4'h0, 32'h0,        1, 0, 32'h0);
    vt[2]  = mk(1, 1, 32'h2000, 4'hF, 32'h11223344, 1, 1, 32'h0);
    vt[3]  = mk(1, 1, 32'h2000, 4'h4, 32'h00AA0000, 1, 1, 32'hDEADBEEF);
    vt[4]  = mk(1, 0, 32'h2000, 4'h0, 32'h0,        1, 1, 32'h0);
    vt[5]  = mk(1, 1, 32'h4008, 4'hF, 32'h55667788, 1, 1, 32'h0);
    vt[6]  = mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h11AA3344);
    vt[7]  = mk(1, 0, 32'h0008, 4'h0, 32'h0,        1, 1, 32'h0);
    vt[8]  = mk(1, 1, 32'h0008, 4'h0, 32'hFFFFFFFF, 1, 0, 32'h0);
    vt[9]  = mk(1, 0, 32'h000B, 4'h0, 32'h0,        1, 1, 32'h55667788);
    vt[10] = mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h0);
    vt[11] = mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h55667788);
    vt[12] = mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 0, 32'h55667788);
    vt[13] = mk(1, 1, 32'h2000, 4'h9, 32'hA0B0C0D0, 1, 0, 32'h55667788);
    vt[14] = mk(1, 0, 32'h2000, 4'h0, 32'h0,        1, 0, 32'h55667788);
    vt[15] = mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'h0);
    vt[16] = mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 1, 32'hA0AA33D0);
    vt[17] = mk(0, 0, 32'h0,    4'h0, 32'h0,        1, 0, 32'hA0AA33D0);

    for (int k = 0; k < 18; k++) begin
      bus2.sram_req = vt[k].req; bus2.sram_wr = vt[k].wr; bus2.sram_addr = vt[k].addr;
      bus2.sram_wstrb = vt[k].wstrb; bus2.sram_wdata = vt[k].wdata;
      chk($sformatf("vec%0d_aok", k), 32'(bus2.sram_addr_ok), 32'(vt[k].aok));
      chk($sformatf("vec%0d_dok", k), 32'(bus2.sram_data_ok), 32'(vt[k].dok));
      chk($sformatf("vec%0d_rdata", k), bus2.sram_rdata, vt[k].rdata);
      tick();
    end
    idle_all();

    // Preload the latency-8 and latency-1 memories
    for (int i = 0; i < 4; i++) pre8[i] = 32'h8000_0000 + 32'(i) * 32'h111;
    for (int i = 0; i < 10; i++) pre1[i] = 32'h1000_0000 ^ (32'(i) * 32'h0101_0101);
    for (int i = 0; i < 10; i++) begin
      bus1.sram_req = 1; bus1.sram_wr = 1; bus1.sram_addr = 32'(i * 4);
      bus1.sram_wstrb = 4'hF; bus1.sram_wdata = pre1[i];
      bus8.sram_req = (i < 4); bus8.sram_wr = 1; bus8.sram_addr = 32'(i * 4);
      bus8.sram_wstrb = 4'hF; bus8.sram_wdata = (i < 4) ? pre8[i] : 32'h0;
      tick();
    end
    idle_all();
    for (int i = 0; i < 12; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Queue full at latency 8: req held six cycles from reset
    begin
      int acc;
      acc = 0;
      for (int c = 0; c < 14; c++) begin
        logic exp_aok, exp_dok;
        bus8.sram_req = (c < 6); bus8.sram_wr = 0; bus8.sram_addr = 32'(acc * 4);
        exp_aok = (c < 4) || (c >= 9);
        exp_dok = (c >= 8) && (c <= 11);
        chk($sformatf("full_c%0d_aok", c), 32'(bus8.sram_addr_ok), 32'(exp_aok));
        chk($sformatf("full_c%0d_dok", c), 32'(bus8.sram_data_ok), 32'(exp_dok));
        if (exp_dok) chk($sformatf("full_c%0d_rdata", c), bus8.sram_rdata, pre8[c-8]);
        if (bus8.sram_req && bus8.sram_addr_ok) acc++;
        tick();
      end
      chk("full_accepts", 32'(acc), 32'd4);
    end
    idle_all();

    // Back-to-back reads at latency 1
    for (int c = 0; c < 12; c++) begin
      bus1.sram_req = (c < 10); bus1.sram_wr = 0; bus1.sram_addr = 32'(c * 4);
      chk($sformatf("b2b_c%0d_aok", c), 32'(bus1.sram_addr_ok), 32'h1);
      chk($sformatf("b2b_c%0d_dok", c), 32'(bus1.sram_data_ok),
          32'((c >= 1) && (c <= 10)));
      if (c >= 1) chk($sformatf("b2b_c%0d_rdata", c), bus1.sram_rdata, pre1[(c > 10) ? 9 : c-1]);
      tick();
    end
    idle_all();

    // Reset with three reads outstanding at latency 8
    for (int i = 0; i < 3; i++) begin
      bus8.sram_req = 1; bus8.sram_wr = 0; bus8.sram_addr = 32'(i * 4);
      tick();
    end
    idle_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("rst_mid_c%0d_dok", c), 32'(bus8.sram_data_ok), 32'h0);
      chk($sformatf("rst_mid_c%0d_aok", c), 32'(bus8.sram_addr_ok), 32'h1);
      tick();
    end
    bus8.sram_req = 1; bus8.sram_wr = 0; bus8.sram_addr = 32'h4;
    tick();
    bus8.sram_req = 0;
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("persist_wait%0d_dok", c), 32'(bus8.sram_data_ok), 32'h0);
      tick();
    end
    chk("persist_dok", 32'(bus8.sram_data_ok), 32'h1);
    chk("persist_rdata", bus8.sram_rdata, pre8[1]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
